issue_ctrl: RTL and testbench

- Hazard and issue controller for the decode stage of the 5-stage RV64 pipeline.
- Owns a register scoreboard for long-latency ops (loads, mul/div) that complete out of band.
- Generates forwarding selects/data for decode operands A/B, plus stall and bubble controls for fetch/decode/execute.
- Counts stall cycles for performance reporting.

---
 rtl/issue_ctrl_pkg.sv | 31 +++
 rtl/issue_ctrl_fwd_mux.sv | 59 +++++
 rtl/issue_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared types and helpers for the decode-stage hazard/issue controller.
package issue_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 64;

  // Which hazard is holding decode; kept for waveform debug.
  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_LOADUSE,
    HZ_SCORE,
    HZ_FULL
  } hazard_t;

  // Pipeline stage supplying a forwarded operand.
  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EX,
    FWD_MEM,
    FWD_WB
  } fwd_src_t;

  // A stage can forward to a source when it is valid, writes, and targets it.
  function automatic logic stage_match(input logic             valid,
                                       input logic             wen,
                                       input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] rs);
    return valid & wen & (dst == rs);
  endfunction

endpackage

// File: rtl/issue_ctrl_fwd_mux.sv
// Per-operand forwarding selector: picks the youngest producing stage
// (EX > MEM > WB) and flags an EX producer whose result is not ready yet.
import issue_ctrl_pkg::*;

module issue_ctrl_fwd_mux (
  input  logic             i_use,
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_ex_valid,
  input  logic             i_ex_wen,
  input  logic [REG_W-1:0] i_ex_dst,
  input  logic             i_ex_long,
  input  logic [XLEN-1:0]  i_ex_res,
  input  logic             i_mem_valid,
  input  logic             i_mem_wen,
  input  logic [REG_W-1:0] i_mem_dst,
  input  logic [XLEN-1:0]  i_mem_res,
  input  logic             i_wb_valid,
  input  logic             i_wb_wen,
  input  logic [REG_W-1:0] i_wb_dst,
  input  logic [XLEN-1:0]  i_wb_res,
  output logic             o_fwd_valid,
  output logic [XLEN-1:0]  o_fwd_data,
  output fwd_src_t         o_fwd_src,
  output logic             o_ld_hit
);

  logic w_active;

  // x0 never forwards and unused sources never need a value.
  assign w_active = i_use & (i_rs != '0);

  // Priority select; an EX producer with a pending result shadows older stages.
  always_comb begin
    o_fwd_valid = 1'b0;
    o_fwd_data  = '0;
    o_fwd_src   = FWD_NONE;
    o_ld_hit    = 1'b0;
    if (w_active) begin
      if (stage_match(i_ex_valid, i_ex_wen, i_ex_dst, i_rs)) begin
        if (i_ex_long) begin
          o_ld_hit = 1'b1;
        end else begin
          o_fwd_valid = 1'b1;
          o_fwd_data  = i_ex_res;
          o_fwd_src   = FWD_EX;
        end
      end else if (stage_match(i_mem_valid, i_mem_wen, i_mem_dst, i_rs)) begin
        o_fwd_valid = 1'b1;
        o_fwd_data  = i_mem_res;
        o_fwd_src   = FWD_MEM;
      end else if (stage_match(i_wb_valid, i_wb_wen, i_wb_dst, i_rs)) begin
        o_fwd_valid = 1'b1;
        o_fwd_data  = i_wb_res;
        o_fwd_src   = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Decode-stage hazard and issue controller: operand forwarding, long-op
// scoreboard, in-flight long-op limit, stall/bubble generation, stall counter.
import issue_ctrl_pkg::*;

module issue_ctrl #(
  parameter int NREG     = 32,
  parameter int MAX_LONG = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             d_valid,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_use1,
  input  logic             d_use2,
  input  logic [4:0]       d_dst,
  input  logic             d_wen,
  input  logic             d_long,
  input  logic             ex_valid,
  input  logic             ex_wen,
  input  logic [4:0]       ex_dst,
  input  logic             ex_long,
  input  logic [63:0]      ex_res,
  input  logic             mem_valid,
  input  logic             mem_wen,
  input  logic [4:0]       mem_dst,
  input  logic [63:0]      mem_res,
  input  logic             wb_valid,
  input  logic             wb_wen,
  input  logic [4:0]       wb_dst,
  input  logic [63:0]      wb_res,
  input  logic             done_valid,
  input  logic [4:0]       done_dst,
  input  logic             redirect,
  input  logic             mem_wait,
  output logic             fwd_valid_a,
  output logic             fwd_valid_b,
  output logic [63:0]      fwd_data_a,
  output logic [63:0]      fwd_data_b,
  output logic             stall_f,
  output logic             stall_d,
  output logic             bubble_e,
  output logic             issue,
  output logic [NREG-1:0]  sb_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LC_W = $clog2(MAX_LONG + 1);

  logic [NREG-1:0]  r_sb;
  logic [LC_W-1:0]  r_long_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_fv_a, w_fv_b;
  logic [XLEN-1:0]  w_fd_a, w_fd_b;
  fwd_src_t         w_src_a, w_src_b;
  logic             w_ld_a, w_ld_b;
  logic             w_sb_hit_a, w_sb_hit_b;
  logic             w_done_eff;
  logic             w_full;
  hazard_t          w_hazard;
  logic             w_hz;
  logic             w_stall;
  logic             w_bubble;
  logic             w_issue;
  logic             w_set;
  logic             w_inc, w_dec;
  logic [NREG-1:0]  w_sb_next;

  issue_ctrl_fwd_mux u_fwd_a (
    .i_use      (d_use1),
    .i_rs       (d_rs1),
    .i_ex_valid (ex_valid),
    .i_ex_wen   (ex_wen),
    .i_ex_dst   (ex_dst),
    .i_ex_long  (ex_long),
    .i_ex_res   (ex_res),
    .i_mem_valid(mem_valid),
    .i_mem_wen  (mem_wen),
    .i_mem_dst  (mem_dst),
    .i_mem_res  (mem_res),
    .i_wb_valid (wb_valid),
    .i_wb_wen   (wb_wen),
    .i_wb_dst   (wb_dst),
    .i_wb_res   (wb_res),
    .o_fwd_valid(w_fv_a),
    .o_fwd_data (w_fd_a),
    .o_fwd_src  (w_src_a),
    .o_ld_hit   (w_ld_a)
  );

  issue_ctrl_fwd_mux u_fwd_b (
    .i_use      (d_use2),
    .i_rs       (d_rs2),
    .i_ex_valid (ex_valid),
    .i_ex_wen   (ex_wen),
    .i_ex_dst   (ex_dst),
    .i_ex_long  (ex_long),
    .i_ex_res   (ex_res),
    .i_mem_valid(mem_valid),
    .i_mem_wen  (mem_wen),
    .i_mem_dst  (mem_dst),
    .i_mem_res  (mem_res),
    .i_wb_valid (wb_valid),
    .i_wb_wen   (wb_wen),
    .i_wb_dst   (wb_dst),
    .i_wb_res   (wb_res),
    .o_fwd_valid(w_fv_b),
    .o_fwd_data (w_fd_b),
    .o_fwd_src  (w_src_b),
    .o_ld_hit   (w_ld_b)
  );

  // A completion only counts when it frees a register that is actually pending.
  assign w_done_eff = done_valid & r_sb[done_dst];

  // Scoreboard hit, bypassed when the same register completes this cycle.
  assign w_sb_hit_a = d_use1 & (d_rs1 != '0) & r_sb[d_rs1]
                    & ~(done_valid & (done_dst == d_rs1));
  assign w_sb_hit_b = d_use2 & (d_rs2 != '0) & r_sb[d_rs2]
                    & ~(done_valid & (done_dst == d_rs2));

  assign w_full = d_long & (r_long_cnt == LC_W'(MAX_LONG)) & ~w_done_eff;

  // Classify the active hazard; anything other than HZ_NONE holds decode.
  always_comb begin
    w_hazard = HZ_NONE;
    if (w_ld_a | w_ld_b) begin
      w_hazard = HZ_LOADUSE;
    end else if (w_sb_hit_a | w_sb_hit_b) begin
      w_hazard = HZ_SCORE;
    end else if (w_full) begin
      w_hazard = HZ_FULL;
    end
  end

  // Redirect squashes decode, so it masks every hazard.
  assign w_hz     = d_valid & ~redirect & (w_hazard != HZ_NONE);
  assign w_stall  = reset_n & (w_hz | mem_wait);
  assign w_bubble = reset_n & ((w_hz & ~mem_wait) | redirect);
  assign w_issue  = reset_n & d_valid & ~(w_hz | mem_wait) & ~redirect;

  assign w_set = w_issue & d_long & d_wen & (d_dst != '0);
  assign w_inc = w_issue & d_long;
  assign w_dec = w_done_eff;

  // Next scoreboard: completion clears first, a new long issue then sets.
  always_comb begin
    w_sb_next = r_sb;
    if (done_valid) begin
      w_sb_next[done_dst] = 1'b0;
    end
    if (w_set) begin
      w_sb_next[d_dst] = 1'b1;
    end
    w_sb_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_next;
    end
  end

  // In-flight long-op count, clamped to [0, MAX_LONG].
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_long_cnt <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10: if (r_long_cnt != LC_W'(MAX_LONG)) r_long_cnt <= r_long_cnt + LC_W'(1);
        2'b01: if (r_long_cnt != '0) r_long_cnt <= r_long_cnt - LC_W'(1);
        default: r_long_cnt <= r_long_cnt;
      endcase
    end
  end

  // Saturating count of cycles in which decode was held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign fwd_valid_a = reset_n & w_fv_a & (w_src_a != FWD_NONE);
  assign fwd_valid_b = reset_n & w_fv_b & (w_src_b != FWD_NONE);
  assign fwd_data_a  = reset_n ? w_fd_a : '0;
  assign fwd_data_b  = reset_n ? w_fd_b : '0;
  assign stall_f     = w_stall;
  assign stall_d     = w_stall;
  assign bubble_e    = w_bubble;
  assign issue       = w_issue;
  assign sb_busy     = r_sb;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl using an expectation queue.
module tb_issue_ctrl;

  logic        clk;
  logic        reset_n;
  logic        d_valid;
  logic [4:0]  d_rs1, d_rs2;
  logic        d_use1, d_use2;
  logic [4:0]  d_dst;
  logic        d_wen, d_long;
  logic        ex_valid, ex_wen;
  logic [4:0]  ex_dst;
  logic        ex_long;
  logic [63:0] ex_res;
  logic        mem_valid, mem_wen;
  logic [4:0]  mem_dst;
  logic [63:0] mem_res;
  logic        wb_valid, wb_wen;
  logic [4:0]  wb_dst;
  logic [63:0] wb_res;
  logic        done_valid;
  logic [4:0]  done_dst;
  logic        redirect, mem_wait;
  logic        fwd_valid_a, fwd_valid_b;
  logic [63:0] fwd_data_a, fwd_data_b;
  logic        stall_f, stall_d, bubble_e, issue;
  logic [31:0] sb_busy;
  logic [31:0] stall_cnt;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  issue_ctrl #(.NREG(32), .MAX_LONG(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use1(d_use1), .d_use2(d_use2), .d_dst(d_dst),
    .d_wen(d_wen), .d_long(d_long),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_dst(ex_dst),
    .ex_long(ex_long), .ex_res(ex_res),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_dst(mem_dst), .mem_res(mem_res),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_dst(wb_dst), .wb_res(wb_res),
    .done_valid(done_valid), .done_dst(done_dst),
    .redirect(redirect), .mem_wait(mem_wait),
    .fwd_valid_a(fwd_valid_a), .fwd_valid_b(fwd_valid_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e), .issue(issue),
    .sb_busy(sb_busy), .stall_cnt(stall_cnt)
  );

  // Free-running pipeline clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(negedge clk);
    reset_n = 1'b1;  d_valid = 1'b0;  d_rs1 = '0;  d_rs2 = '0;
    d_use1 = 1'b0;   d_use2 = 1'b0;   d_dst = '0;  d_wen = 1'b0;  d_long = 1'b0;
    ex_valid = 1'b0; ex_wen = 1'b0;   ex_dst = '0; ex_long = 1'b0; ex_res = '0;
    mem_valid = 1'b0; mem_wen = 1'b0; mem_dst = '0; mem_res = '0;
    wb_valid = 1'b0; wb_wen = 1'b0;   wb_dst = '0; wb_res = '0;
    done_valid = 1'b0; done_dst = '0; redirect = 1'b0; mem_wait = 1'b0;
  endtask

  task automatic expectVal(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, no expectation queued", tag, obs);
    end else begin
      e = expQ.pop_front();
      assert (obs === e.val && tag == e.tag) else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h (queued tag %s)", tag, obs, e.val, e.tag);
      end
    end
  endtask

  initial begin
    // Reset with hazardous inputs: comb outputs must be forced low.
    applyStimulus();
    reset_n = 1'b0; d_valid = 1'b1; d_rs1 = 5'd5; d_use1 = 1'b1;
    ex_valid = 1'b1; ex_wen = 1'b1; ex_dst = 5'd5; ex_res = 64'h11;
    redirect = 1'b1; mem_wait = 1'b1;
    expectVal("rst_fwdA", 0); expectVal("rst_bubble", 0);
    expectVal("rst_stall", 0); expectVal("rst_issue", 0);
    #1;
    checkOutput("rst_fwdA", fwd_valid_a); checkOutput("rst_bubble", bubble_e);
    checkOutput("rst_stall", stall_d);    checkOutput("rst_issue", issue);

    // Forwarding priority EX > MEM > WB.
    applyStimulus();
    expectVal("rst_sb", 0); expectVal("rst_cnt", 0);
    #1;
    checkOutput("rst_sb", sb_busy); checkOutput("rst_cnt", stall_cnt);
    d_valid = 1'b1; d_rs1 = 5'd5; d_use1 = 1'b1; d_rs2 = 5'd5;
    ex_valid = 1'b1; ex_wen = 1'b1; ex_dst = 5'd5; ex_res = 64'h11;
    mem_valid = 1'b1; mem_wen = 1'b1; mem_dst = 5'd5; mem_res = 64'h22;
    wb_valid = 1'b1; wb_wen = 1'b1; wb_dst = 5'd5; wb_res = 64'h33;
    expectVal("ex_fwdA", 1); expectVal("ex_dataA", 64'h11);
    expectVal("ex_fwdB_unused", 0); expectVal("ex_stall", 0); expectVal("ex_issue", 1);
    #1;
    checkOutput("ex_fwdA", fwd_valid_a); checkOutput("ex_dataA", fwd_data_a);
    checkOutput("ex_fwdB_unused", fwd_valid_b); checkOutput("ex_stall", stall_d);
    checkOutput("ex_issue", issue);
    ex_valid = 1'b0;
    expectVal("mem_dataA", 64'h22);
    #1;
    checkOutput("mem_dataA", fwd_data_a);
    mem_wen = 1'b0;
    expectVal("wb_dataA", 64'h33);
    #1;
    checkOutput("wb_dataA", fwd_data_a);

    // Load-use stall, then MEM forwarding releases it.
    applyStimulus();
    d_valid = 1'b1; d_rs2 = 5'd7; d_use2 = 1'b1;
    ex_valid = 1'b1; ex_wen = 1'b1; ex_dst = 5'd7; ex_long = 1'b1; ex_res = 64'hdead;
    expectVal("lu_stallD", 1); expectVal("lu_stallF", 1);
    expectVal("lu_bubble", 1); expectVal("lu_issue", 0); expectVal("lu_fwdB", 0);
    #1;
    checkOutput("lu_stallD", stall_d); checkOutput("lu_stallF", stall_f);
    checkOutput("lu_bubble", bubble_e); checkOutput("lu_issue", issue);
    checkOutput("lu_fwdB", fwd_valid_b);
    applyStimulus();
    d_valid = 1'b1; d_rs2 = 5'd7; d_use2 = 1'b1;
    mem_valid = 1'b1; mem_wen = 1'b1; mem_dst = 5'd7; mem_res = 64'h77;
    expectVal("lu2_fwdB", 1); expectVal("lu2_dataB", 64'h77);
    expectVal("lu2_issue", 1); expectVal("lu2_cnt", 1);
    #1;
    checkOutput("lu2_fwdB", fwd_valid_b); checkOutput("lu2_dataB", fwd_data_b);
    checkOutput("lu2_issue", issue); checkOutput("lu2_cnt", stall_cnt);

    // Long op to x9, dependent reader stalls, completion bypasses.
    applyStimulus();
    d_valid = 1'b1; d_long = 1'b1; d_wen = 1'b1; d_dst = 5'd9;
    expectVal("lg_issue", 1);
    #1;
    checkOutput("lg_issue", issue);
    applyStimulus();
    d_valid = 1'b1; d_rs1 = 5'd9; d_use1 = 1'b1;
    expectVal("lg_sb9", 32'h0000_0200); expectVal("lg_dep_stall", 1); expectVal("lg_dep_issue", 0);
    #1;
    checkOutput("lg_sb9", sb_busy); checkOutput("lg_dep_stall", stall_d);
    checkOutput("lg_dep_issue", issue);
    applyStimulus();
    d_valid = 1'b1; d_rs1 = 5'd9; d_use1 = 1'b1; done_valid = 1'b1; done_dst = 5'd9;
    expectVal("lg_done_issue", 1); expectVal("lg_done_stall", 0);
    #1;
    checkOutput("lg_done_issue", issue); checkOutput("lg_done_stall", stall_d);
    applyStimulus();
    expectVal("lg_sb_clear", 0); expectVal("lg_cnt", 2);
    #1;
    checkOutput("lg_sb_clear", sb_busy); checkOutput("lg_cnt", stall_cnt);

    // Fill the long-op limit with x10..x13.
    for (int i = 0; i < 4; i++) begin
      if (i != 0) applyStimulus();
      d_valid = 1'b1; d_long = 1'b1; d_wen = 1'b1; d_dst = 5'(10 + i);
      expectVal("fill_issue", 1);
      #1;
      checkOutput("fill_issue", issue);
    end
    applyStimulus();
    d_valid = 1'b1; d_long = 1'b1; d_wen = 1'b1; d_dst = 5'd14;
    expectVal("full_sb", 32'h0000_3c00); expectVal("full_stall", 1); expectVal("full_issue", 0);
    #1;
    checkOutput("full_sb", sb_busy); checkOutput("full_stall", stall_d);
    checkOutput("full_issue", issue);
    applyStimulus();
    d_valid = 1'b1; d_long = 1'b1; d_wen = 1'b1; d_dst = 5'd14;
    expectVal("full_cnt", 3); expectVal("full_stall2", 1);
    #1;
    checkOutput("full_cnt", stall_cnt); checkOutput("full_stall2", stall_d);
    applyStimulus();
    d_valid = 1'b1; d_long = 1'b1; d_wen = 1'b1; d_dst = 5'd14;
    done_valid = 1'b1; done_dst = 5'd10;
    expectVal("full_cnt2", 4); expectVal("full_done_issue", 1);
    #1;
    checkOutput("full_cnt2", stall_cnt); checkOutput("full_done_issue", issue);
    applyStimulus();
    d_valid = 1'b1; d_long = 1'b1; d_wen = 1'b1; d_dst = 5'd15;
    expectVal("swap_sb", 32'h0000_7800); expectVal("still_full", 1);
    #1;
    checkOutput("swap_sb", sb_busy); checkOutput("still_full", stall_d);

    // Redirect with hazards present: squash, no stall, no scoreboard set.
    applyStimulus();
    d_valid = 1'b1; d_long = 1'b1; d_wen = 1'b1; d_dst = 5'd15;
    d_rs1 = 5'd11; d_use1 = 1'b1; redirect = 1'b1;
    expectVal("rd_issue", 0); expectVal("rd_bubble", 1); expectVal("rd_stall", 0);
    #1;
    checkOutput("rd_issue", issue); checkOutput("rd_bubble", bubble_e);
    checkOutput("rd_stall", stall_d);

    // x0 source never forwards nor stalls, even against a pending EX load.
    applyStimulus();
    d_valid = 1'b1; d_rs1 = 5'd0; d_use1 = 1'b1;
    ex_valid = 1'b1; ex_wen = 1'b1; ex_dst = 5'd0; ex_long = 1'b1; ex_res = 64'h55;
    expectVal("rd_sb_keep", 32'h0000_7800); expectVal("x0_cnt", 5);
    expectVal("x0_fwdA", 0); expectVal("x0_stall", 0); expectVal("x0_issue", 1);
    #1;
    checkOutput("rd_sb_keep", sb_busy); checkOutput("x0_cnt", stall_cnt);
    checkOutput("x0_fwdA", fwd_valid_a); checkOutput("x0_stall", stall_d);
    checkOutput("x0_issue", issue);

    // mem_wait holds decode without inserting a bubble.
    applyStimulus();
    d_valid = 1'b1; mem_wait = 1'b1;
    expectVal("mw_stall", 1); expectVal("mw_bubble", 0); expectVal("mw_issue", 0);
    #1;
    checkOutput("mw_stall", stall_d); checkOutput("mw_bubble", bubble_e);
    checkOutput("mw_issue", issue);

    // Mid-run reset with a completion pending clears all state.
    applyStimulus();
    reset_n = 1'b0; done_valid = 1'b1; done_dst = 5'd11; d_valid = 1'b1; mem_wait = 1'b1;
    expectVal("pre_rst_sb", 32'h0000_7800); expectVal("pre_rst_cnt", 6);
    expectVal("in_rst_stall", 0);
    #1;
    checkOutput("pre_rst_sb", sb_busy); checkOutput("pre_rst_cnt", stall_cnt);
    checkOutput("in_rst_stall", stall_d);
    applyStimulus();
    d_valid = 1'b1; d_long = 1'b1; d_wen = 1'b1; d_dst = 5'd20;
    expectVal("post_rst_sb", 0); expectVal("post_rst_cnt", 0); expectVal("post_rst_issue", 1);
    #1;
    checkOutput("post_rst_sb", sb_busy); checkOutput("post_rst_cnt", stall_cnt);
    checkOutput("post_rst_issue", issue);

    checks++;
    assert (expQ.size() === 0) else begin
      errors++;
      $error("[TB] FAIL queue_drain: observed %0d entries expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
